vga_pattern_sequencer: RTL and testbench
========================================

VGA_PATTERN_SEQUENCER -- requirements
Module: vga_pattern_sequencer

Interface
REQ-001 SHALL have parameter FRAMES_PER_PATTERN, default 60: frames each pattern is shown in auto mode; legal range 1..255.
REQ-002 SHALL have port clk, input, 1 bit: single system clock, 125 MHz; all logic is synchronous to clk.
REQ-003 SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port i_vs, input, 1 bit: vertical sync from the timing generator, active-low pulse, synchronous to clk.
REQ-005 SHALL have port i_req, input, 1 bit: manual pattern-change request, sampled every cycle.
REQ-006 SHALL have port i_req_pat, input, 2 bits: requested pattern; qualified by i_req.
REQ-007 SHALL have port i_auto, input, 1 bit: 1 = auto-cycle patterns, 0 = hold the current pattern.
REQ-008 SHALL have port o_pattern_select, output, 2 bits: pattern index driven to the pattern generator.
REQ-009 SHALL have port o_ack, output, 1 bit: one-cycle pulse when a manual request is applied.
REQ-010 SHALL have port o_busy, output, 1 bit: a manual request is pending.
REQ-011 SHALL have port o_frame_cnt, output, 8 bits: frames elapsed since the last pattern change.

Function
REQ-012 SHALL register i_vs into vs_d; frame boundary fb = vs_d & ~i_vs, i.e. the first cycle i_vs is sampled low.
REQ-013 SHALL implement a state machine with states IDLE and PENDING.
REQ-014 IDLE with i_req=1: SHALL latch i_req_pat, enter PENDING and set o_busy=1 on the next edge, even if fb=1 in the same cycle (application waits for the next boundary).
REQ-015 PENDING with i_req=1: SHALL overwrite the latched pattern (last request wins), with no extra o_ack.
REQ-016 PENDING with fb=1: SHALL load o_pattern_select from the latch, pulse o_ack=1 for exactly one cycle, clear o_busy, clear o_frame_cnt to 0 and return to IDLE.
REQ-017 If PENDING, fb=1 and i_req=1 all coincide: SHALL apply the new i_req_pat value.
REQ-018 o_pattern_select SHALL change only on an edge where fb=1 (never mid-frame).
REQ-019 Auto mode, on fb=1 with no apply occurring: SHALL increment o_frame_cnt.
REQ-020 Auto mode: when o_frame_cnt == FRAMES_PER_PATTERN-1 at fb, SHALL set o_pattern_select to (o_pattern_select+1) mod 4 (3 wraps to 0) and clear o_frame_cnt.
REQ-021 A manual apply SHALL take priority over an auto advance on the same boundary.
REQ-022 i_auto=0: o_frame_cnt SHALL still count and saturate at 255; no auto advance.
REQ-023 Deasserting i_auto SHALL NOT alter o_pattern_select or o_frame_cnt.

Reset
REQ-024 While rstn=0 at an edge: o_pattern_select=0, o_ack=0, o_busy=0, o_frame_cnt=0, state=IDLE, vs_d=1.
REQ-025 Reset mid-operation SHALL discard any pending request without an o_ack.
REQ-026 vs_d=1 at reset: if i_vs is low at release, SHALL flag a boundary on the first active cycle.

Configuration
REQ-027 Macro PATTERN_AUTO_CYCLE_EN defined: SHALL implement auto cycling (REQ-019..REQ-022).
REQ-028 Macro PATTERN_AUTO_CYCLE_EN undefined: i_auto is ignored, no frame counter is built, o_frame_cnt is tied to 0, pattern changes only by manual request; ports unchanged.

Verification
REQ-029 Reset, then i_req=1 with i_req_pat=2 for one cycle -> o_busy=1 next cycle; at the next i_vs fall, o_pattern_select=2 and a single 1-cycle o_ack; o_busy=0.
REQ-030 Two requests (1 then 3) before one boundary -> o_pattern_select=3 at the boundary, exactly one o_ack.
REQ-031 Request coinciding with fb -> no change at that boundary; applied at the following boundary.
REQ-032 FRAMES_PER_PATTERN=2, i_auto=1, 8 vsync pulses -> o_pattern_select sequence 0,1,2,3,0 (change every 2nd boundary).
REQ-033 Pending request, rstn=0 for one cycle, then vsync -> o_pattern_select=0, o_ack never asserted.
REQ-034 Build without PATTERN_AUTO_CYCLE_EN, i_auto=1, 10 frames -> o_pattern_select stays 0, o_frame_cnt=0.

Source files
------------

// File: rtl/vga_pattern_sequencer.sv
// Test-pattern sequencer: applies manual pattern requests on vsync frame boundaries.
// Auto cycling and the frame counter are built only when PATTERN_AUTO_CYCLE_EN is defined.
module vga_pattern_sequencer #(
   parameter int unsigned FRAMES_PER_PATTERN = 60
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       i_vs,
   input  logic       i_req,
   input  logic [1:0] i_req_pat,
   input  logic       i_auto,
   output logic [1:0] o_pattern_select,
   output logic       o_ack,
   output logic       o_busy,
   output logic [7:0] o_frame_cnt
);

   typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

   state_t     state;
   logic       vs_d;
   logic       fb;
   logic       apply;
   logic [1:0] pend_pat;
   logic [1:0] apply_pat;

   assign fb    = vs_d & ~i_vs;
   assign apply = (state == PENDING) && fb;
   // A request landing on the applying boundary still wins over the latched one
   assign apply_pat = i_req ? i_req_pat : pend_pat;

   // Request handshake: latch, hold until a frame boundary, then acknowledge
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= IDLE;
         vs_d     <= 1'b1;
         pend_pat <= 2'd0;
         o_ack    <= 1'b0;
         o_busy   <= 1'b0;
      end else begin
         vs_d  <= i_vs;
         o_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (i_req) begin
                  pend_pat <= i_req_pat;
                  o_busy   <= 1'b1;
                  state    <= PENDING;
               end
            end
            PENDING: begin
               if (fb) begin
                  o_ack  <= 1'b1;
                  o_busy <= 1'b0;
                  state  <= IDLE;
               end else if (i_req) begin
                  pend_pat <= i_req_pat;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PATTERN_AUTO_CYCLE_EN
   localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_PATTERN - 1);

   logic [7:0] frame_cnt;
   logic       advance;

   assign advance     = fb && i_auto && (frame_cnt == LAST_FRAME);
   assign o_frame_cnt = frame_cnt;

   // Manual apply outranks auto advance; the counter saturates when not cycling
   always_ff @(posedge clk) begin
      if (!rstn) begin
         o_pattern_select <= 2'd0;
         frame_cnt        <= 8'd0;
      end else if (apply) begin
         o_pattern_select <= apply_pat;
         frame_cnt        <= 8'd0;
      end else if (advance) begin
         o_pattern_select <= o_pattern_select + 2'd1;
         frame_cnt        <= 8'd0;
      end else if (fb && (frame_cnt != 8'hFF)) begin
         frame_cnt <= frame_cnt + 8'd1;
      end
   end
`else
   logic unused_auto;
   assign unused_auto = i_auto;
   assign o_frame_cnt = 8'd0;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         o_pattern_select <= 2'd0;
      end else if (apply) begin
         o_pattern_select <= apply_pat;
      end
   end
`endif

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Scoreboard bench for vga_pattern_sequencer; auto-cycle cases run when PATTERN_AUTO_CYCLE_EN is defined.
module tb_vga_pattern_sequencer;

   localparam int unsigned FPP = 2;
`ifdef PATTERN_AUTO_CYCLE_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   typedef struct packed {
      logic [1:0] pat;
      logic [7:0] cnt;
      logic       busy;
   } frame_exp_t;

   logic       clk;
   logic       rstn;
   logic       i_vs;
   logic       i_req;
   logic [1:0] i_req_pat;
   logic       i_auto;
   logic [1:0] o_pattern_select;
   logic       o_ack;
   logic       o_busy;
   logic [7:0] o_frame_cnt;

   int         n_checks;
   int         n_fail;
   int         n_ack;
   bit         mon_en;
   bit         chg_ok;
   logic [1:0] last_pat;
   logic [1:0] ack_q[$];
   frame_exp_t frame_q[$];

   vga_pattern_sequencer #(.FRAMES_PER_PATTERN(FPP)) dut (
      .clk              (clk),
      .rstn             (rstn),
      .i_vs             (i_vs),
      .i_req            (i_req),
      .i_req_pat        (i_req_pat),
      .i_auto           (i_auto),
      .o_pattern_select (o_pattern_select),
      .o_ack            (o_ack),
      .o_busy           (o_busy),
      .o_frame_cnt      (o_frame_cnt)
   );

   initial clk = 1'b0;
   always #4 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] c(input int x);
      return AUTO ? 8'(x) : 8'd0;
   endfunction

   function automatic void push_frame(input logic [1:0] pat, input logic [7:0] cnt, input logic busy);
      frame_exp_t e;
      e.pat  = pat;
      e.cnt  = cnt;
      e.busy = busy;
      frame_q.push_back(e);
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic vs_lvl);
      rstn      = 1'b0;
      i_vs      = vs_lvl;
      i_req     = 1'b0;
      i_req_pat = 2'd0;
      @(posedge clk);
      #1;
      chg_ok = 1'b1;
      check("rst_pattern", 32'(o_pattern_select), 32'd0);
      check("rst_ack", 32'(o_ack), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
      rstn = 1'b1;
   endtask

   task automatic request(input logic [1:0] p);
      i_req     = 1'b1;
      i_req_pat = p;
      @(posedge clk);
      #1;
      i_req = 1'b0;
      check("busy_after_req", 32'(o_busy), 32'd1);
   endtask

   // vsync low for 3 cycles then high for 4; optional request on the falling edge
   task automatic frame(input bit with_req, input logic [1:0] rp);
      frame_exp_t e;
      i_vs = 1'b0;
      if (with_req) begin
         i_req     = 1'b1;
         i_req_pat = rp;
      end
      @(posedge clk);
      #1;
      chg_ok = 1'b1;
      i_req  = 1'b0;
      check("frame_q_nonempty", 32'(frame_q.size() != 0), 32'd1);
      if (frame_q.size() != 0) begin
         e = frame_q.pop_front();
         check("pat_at_fb", 32'(o_pattern_select), 32'(e.pat));
         check("cnt_at_fb", 32'(o_frame_cnt), 32'(e.cnt));
         check("busy_at_fb", 32'(o_busy), 32'(e.busy));
      end
      step(1);
      check("ack_one_cycle", 32'(o_ack), 32'd0);
      step(1);
      i_vs = 1'b1;
      step(4);
   endtask

   // Acks are matched against the scoreboard; pattern may move only right after a boundary or reset
   always @(negedge clk) begin
      if (mon_en) begin
         if (o_ack === 1'b1) begin
            n_ack++;
            check("ack_expected", 32'(ack_q.size() != 0), 32'd1);
            if (ack_q.size() != 0)
               check("ack_pat", 32'(o_pattern_select), 32'(ack_q.pop_front()));
         end
         if (o_pattern_select !== last_pat)
            check("pat_change_off_boundary", 32'(chg_ok), 32'd1);
         last_pat = o_pattern_select;
         chg_ok   = 1'b0;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

`ifdef PATTERN_AUTO_CYCLE_EN
   logic [1:0] auto_pat [8];
   logic [7:0] auto_cnt [8];
   initial begin
      auto_pat = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
      auto_cnt = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0};
   end
`endif

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      n_ack     = 0;
      mon_en    = 1'b0;
      chg_ok    = 1'b0;
      rstn      = 1'b0;
      i_vs      = 1'b1;
      i_req     = 1'b0;
      i_req_pat = 2'd0;
      i_auto    = 1'b0;
      step(1);
      do_reset(1'b1);
      last_pat = o_pattern_select;
      mon_en   = 1'b1;

      // single request applied at the next boundary
      request(2'd2);
      step(3);
      check("pat_hold_pending", 32'(o_pattern_select), 32'd0);
      check("busy_hold_pending", 32'(o_busy), 32'd1);
      ack_q.push_back(2'd2);
      push_frame(2'd2, 8'd0, 1'b0);
      frame(1'b0, 2'd0);
      check("ack_count_single", 32'(n_ack), 32'd1);

      // last request wins, one ack
      request(2'd1);
      step(2);
      request(2'd3);
      ack_q.push_back(2'd3);
      push_frame(2'd3, 8'd0, 1'b0);
      frame(1'b0, 2'd0);
      check("ack_count_last_wins", 32'(n_ack), 32'd2);

      // request on the boundary while idle waits for the following one
      push_frame(2'd3, c(1), 1'b1);
      frame(1'b1, 2'd1);
      check("ack_count_coincident", 32'(n_ack), 32'd2);
      ack_q.push_back(2'd1);
      push_frame(2'd1, 8'd0, 1'b0);
      frame(1'b0, 2'd0);

      // pending plus a request on the applying boundary takes the new value
      request(2'd0);
      ack_q.push_back(2'd2);
      push_frame(2'd2, 8'd0, 1'b0);
      frame(1'b1, 2'd2);
      check("ack_count_req_at_apply", 32'(n_ack), 32'd4);

      // reset discards a pending request
      request(2'd1);
      do_reset(1'b1);
      push_frame(2'd0, c(1), 1'b0);
      frame(1'b0, 2'd0);
      check("ack_count_reset_discard", 32'(n_ack), 32'd4);

      // vsync already low at reset release counts as a boundary
      do_reset(1'b0);
      step(1);
      check("cnt_fb_at_release", 32'(o_frame_cnt), 32'(c(1)));
      i_vs = 1'b1;
      step(3);

`ifdef PATTERN_AUTO_CYCLE_EN
      // auto cycling every FPP boundaries with wrap
      do_reset(1'b1);
      i_auto = 1'b1;
      for (int k = 0; k < 8; k++) push_frame(auto_pat[k], auto_cnt[k], 1'b0);
      for (int k = 0; k < 8; k++) frame(1'b0, 2'd0);

      // manual apply outranks auto advance on the same boundary
      push_frame(2'd0, 8'd1, 1'b0);
      frame(1'b0, 2'd0);
      request(2'd2);
      ack_q.push_back(2'd2);
      push_frame(2'd2, 8'd0, 1'b0);
      frame(1'b0, 2'd0);

      // dropping auto leaves pattern and count untouched
      push_frame(2'd2, 8'd1, 1'b0);
      frame(1'b0, 2'd0);
      i_auto = 1'b0;
      step(3);
      check("auto_off_pat", 32'(o_pattern_select), 32'd2);
      check("auto_off_cnt", 32'(o_frame_cnt), 32'd1);

      // counter saturates at 255 with no advance
      for (int k = 0; k < 260; k++) begin
         push_frame(2'd2, 8'((2 + k) > 255 ? 255 : (2 + k)), 1'b0);
         frame(1'b0, 2'd0);
      end
`else
      // auto request ignored without the feature
      do_reset(1'b1);
      i_auto = 1'b1;
      for (int k = 0; k < 10; k++) begin
         push_frame(2'd0, 8'd0, 1'b0);
         frame(1'b0, 2'd0);
      end
`endif

      check("ack_count_total", 32'(n_ack), AUTO ? 32'd5 : 32'd4);
      check("ack_q_drained", 32'(ack_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
